csr_exec: RTL and testbench

- Sequencing stage directly upstream of the CSR register file (`csr`).
- Accepts one decoded CSR / ECALL / MRET instruction at a time from the execute pipe and reads the old CSR value from the `csr_pack` snapshot.
- Computes CSRRW/RS/RC(I) write data and drives a single-cycle `csr_writer` pulse into `csr`.
- Consumes `csr`'s `new_pmode`/`update_pmode`, owns the architectural privilege-mode register, and issues the trap/return PC redirect.

---
 rtl/csr_exec_pkg.sv | 59 +++++
 rtl/csr_exec_if.sv | 27 ++
 rtl/csr_exec_read_mux.sv | 28 ++
 rtl/csr_exec.sv | 135 +++++++++++++
 tb/tb_csr_exec.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/csr_exec_pkg.sv
// Shared CSR types for the execute-side CSR sequencer and the CSR register file.
// Defines the CSR snapshot and write-command structs plus the CSR address map.
package csr_exec_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_SATP     = 12'h180;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    // Addresses with both top bits set are read-only.
    localparam logic [11:0] CSR_RO_MASK  = 12'hC00;

    typedef enum logic [2:0] {
        F3_RW  = 3'b001,
        F3_RS  = 3'b010,
        F3_RC  = 3'b011,
        F3_RWI = 3'b101,
        F3_RSI = 3'b110,
        F3_RCI = 3'b111
    } csr_funct3_t;

    typedef enum logic [1:0] {IDLE, EXEC, COMMIT, RESP} csr_exec_state_t;

    typedef struct packed {
        logic [63:0] mstatus;
        logic [63:0] mtvec;
        logic [63:0] mip;
        logic [63:0] mie;
        logic [63:0] mscratch;
        logic [63:0] mcause;
        logic [63:0] mtval;
        logic [63:0] mepc;
        logic [63:0] mcycle;
        logic [63:0] mhartid;
        logic [63:0] satp;
    } csr_pack;

    typedef struct packed {
        logic        csr_write_enable;
        logic        plain;
        logic        ecall;
        logic        mret;
        logic [63:0] pc;
        logic [11:0] csr_dest_addr;
        logic [63:0] csr_write_data;
    } csr_writer;

    function automatic logic is_csr_ro(input logic [11:0] addr);
        return (addr & CSR_RO_MASK) == CSR_RO_MASK;
    endfunction

endpackage

// File: rtl/csr_exec_if.sv
// Request/response bus between the execute pipe and the CSR sequencer.
interface csr_exec_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic [11:0] in_csr_addr;
    logic [4:0]  in_rs1;
    logic [63:0] in_src;
    logic [63:0] in_pc;
    logic        in_ecall;
    logic        in_mret;
    logic        out_valid;
    logic [63:0] out_rd_data;
    logic        out_illegal;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    modport master (
        output in_valid, in_funct3, in_csr_addr, in_rs1, in_src, in_pc, in_ecall, in_mret,
        input  in_ready, out_valid, out_rd_data, out_illegal, redirect_valid, redirect_pc
    );

    modport slave (
        input  in_valid, in_funct3, in_csr_addr, in_rs1, in_src, in_pc, in_ecall, in_mret,
        output in_ready, out_valid, out_rd_data, out_illegal, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/csr_exec_read_mux.sv
// Combinational CSR read mux over the csr_pack snapshot; unknown addresses read 0.
module csr_read_mux
    import csr_exec_pkg::*;
(
    input  csr_pack     csrs_i,
    input  logic [11:0] addr_i,
    output logic [63:0] value_o,
    output logic        illegal_o
);
    always_comb begin
        value_o   = '0;
        illegal_o = 1'b0;
        case (addr_i)
            CSR_MSTATUS:  value_o = csrs_i.mstatus;
            CSR_MTVEC:    value_o = csrs_i.mtvec;
            CSR_MIP:      value_o = csrs_i.mip;
            CSR_MIE:      value_o = csrs_i.mie;
            CSR_MSCRATCH: value_o = csrs_i.mscratch;
            CSR_MCAUSE:   value_o = csrs_i.mcause;
            CSR_MTVAL:    value_o = csrs_i.mtval;
            CSR_MEPC:     value_o = csrs_i.mepc;
            CSR_MCYCLE:   value_o = csrs_i.mcycle;
            CSR_MHARTID:  value_o = csrs_i.mhartid;
            CSR_SATP:     value_o = csrs_i.satp;
            default:      illegal_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/csr_exec.sv
// Fixed-latency CSR / ECALL / MRET sequencer feeding the CSR register file.
// Owns the privilege-mode register and issues trap/return redirects.
//
// state  | meaning
// IDLE   | ready, latch request on in_valid
// EXEC   | read old value, compute write data and legality
// COMMIT | drive registered writer pulse into csr
// RESP   | completion pulse, redirect, privilege update
module csr_exec
    import csr_exec_pkg::*;
#(
    parameter logic [1:0] RESET_PMODE = 2'd3
) (
    input  logic            clk,
    input  logic            rst,
    csr_exec_if.slave       bus,
    input  csr_pack         csrs,
    input  logic [1:0]      new_pmode,
    input  logic            update_pmode,
    output csr_writer       writer,
    output logic [1:0]      pmode
);
    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_EXEC   = EXEC;
    localparam logic [1:0] S_COMMIT = COMMIT;
    localparam logic [1:0] S_RESP   = RESP;

    logic [1:0]  state_q, state_d;
    logic [2:0]  funct3_q;
    logic [11:0] addr_q;
    logic [4:0]  rs1_q;
    logic [63:0] src_q, pc_q, rd_data_q;
    logic        ecall_q, mret_q, illegal_q;
    logic [1:0]  pmode_q;
    csr_writer   writer_q, writer_d;

    logic [63:0] old_val, operand, wdata;
    logic        rd_illegal, suppress, illegal, sys;

    csr_read_mux u_read_mux (
        .csrs_i    (csrs),
        .addr_i    (addr_q),
        .value_o   (old_val),
        .illegal_o (rd_illegal)
    );

    always_comb begin
        operand  = funct3_q[2] ? {59'd0, rs1_q} : src_q;
        suppress = (funct3_q[1:0] != 2'b01) && (rs1_q == 5'd0);
        sys      = ecall_q || mret_q;
        wdata    = '0;
        case (funct3_q[1:0])
            2'b01:   wdata = operand;
            2'b10:   wdata = old_val | operand;
            2'b11:   wdata = old_val & ~operand;
            default: wdata = '0;
        endcase
        // funct3 x00 is not a CSR op; treat it as illegal rather than silently dropping it.
        illegal = rd_illegal || (funct3_q[1:0] == 2'b00) || (!suppress && is_csr_ro(addr_q));
    end

    always_comb begin
        writer_d = '0;
        if (state_q == S_EXEC) begin
            if (ecall_q) begin
                writer_d.csr_write_enable = 1'b1;
                writer_d.ecall            = 1'b1;
                writer_d.pc               = pc_q;
            end else if (mret_q) begin
                writer_d.csr_write_enable = 1'b1;
                writer_d.mret             = 1'b1;
            end else if (!illegal && !suppress) begin
                writer_d.csr_write_enable = 1'b1;
                writer_d.plain            = 1'b1;
                writer_d.csr_dest_addr    = addr_q;
                writer_d.csr_write_data   = wdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.in_valid) state_d = S_EXEC;
            S_EXEC:   state_d = S_COMMIT;
            S_COMMIT: state_d = S_RESP;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            funct3_q  <= '0;
            addr_q    <= '0;
            rs1_q     <= '0;
            src_q     <= '0;
            pc_q      <= '0;
            ecall_q   <= 1'b0;
            mret_q    <= 1'b0;
            rd_data_q <= '0;
            illegal_q <= 1'b0;
            writer_q  <= '0;
            pmode_q   <= RESET_PMODE;
        end else begin
            state_q  <= state_d;
            writer_q <= writer_d;
            if (state_q == S_IDLE && bus.in_valid) begin
                funct3_q <= bus.in_funct3;
                addr_q   <= bus.in_csr_addr;
                rs1_q    <= bus.in_rs1;
                src_q    <= bus.in_src;
                pc_q     <= bus.in_pc;
                ecall_q  <= bus.in_ecall;
                mret_q   <= bus.in_mret;
            end
            if (state_q == S_EXEC) begin
                rd_data_q <= sys ? '0 : old_val;
                illegal_q <= sys ? 1'b0 : illegal;
            end
            if (state_q == S_RESP && update_pmode) pmode_q <= new_pmode;
        end
    end

    assign writer             = writer_q;
    assign pmode              = pmode_q;
    assign bus.in_ready       = (state_q == S_IDLE);
    assign bus.out_valid      = (state_q == S_RESP);
    assign bus.out_rd_data    = bus.out_valid ? rd_data_q : '0;
    assign bus.out_illegal    = bus.out_valid && illegal_q;
    assign bus.redirect_valid = bus.out_valid && (ecall_q || mret_q);
    // mtvec/mepc are read live so the redirect sees the values csr committed last cycle.
    assign bus.redirect_pc    = !bus.redirect_valid ? '0 :
                                ecall_q ? {csrs.mtvec[63:2], 2'b00} : csrs.mepc;
endmodule

// File: tb/tb_csr_exec.sv
// Self-checking bench for csr_exec: directed cases plus randomized CSR traffic
// checked against a behavioural model of the CSR instruction semantics.
module tb_csr_exec;
    import csr_exec_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    csr_pack    csrs_s;
    logic [1:0] new_pmode;
    logic       update_pmode;
    csr_writer  writer;
    logic [1:0] pmode;

    csr_exec_if bus ();

    csr_exec #(.RESET_PMODE(2'd3)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .csrs         (csrs_s),
        .new_pmode    (new_pmode),
        .update_pmode (update_pmode),
        .writer       (writer),
        .pmode        (pmode)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [1:0] pm_exp = 2'd3;
    bit         pm_rand = 1'b0;
    bit         upd_fix = 1'b0;
    logic [1:0] np_fix  = 2'd0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_read(input logic [11:0] a, input csr_pack c, output logic [63:0] v);
        v = '0;
        case (a)
            12'h300: v = c.mstatus;
            12'h305: v = c.mtvec;
            12'h344: v = c.mip;
            12'h304: v = c.mie;
            12'h340: v = c.mscratch;
            12'h342: v = c.mcause;
            12'h343: v = c.mtval;
            12'h341: v = c.mepc;
            12'hB00: v = c.mcycle;
            12'hF14: v = c.mhartid;
            12'h180: v = c.satp;
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    task automatic drive_pm();
        if (pm_rand) begin
            update_pmode = 1'($urandom_range(0, 1));
            new_pmode    = 2'($urandom_range(0, 3));
        end else begin
            update_pmode = upd_fix;
            new_pmode    = np_fix;
        end
    endtask

    task automatic run_txn(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1,
                           input logic [63:0] src, input logic [63:0] pc, input bit ec, input bit mr);
        csr_writer   w_exp;
        logic [63:0] old, op, nv, rpc_exp, rd_exp;
        bit          known, wr, ill_exp;
        known = ref_read(addr, csrs_s, old);
        op    = f3[2] ? {59'd0, rs1} : src;
        wr    = (f3[1:0] == 2'b01) || (rs1 != 5'd0);
        nv    = (f3[1:0] == 2'b01) ? op : (f3[1:0] == 2'b10) ? (old | op) : (old & ~op);
        w_exp = '0;
        ill_exp = 1'b0;
        rd_exp  = '0;
        if (ec) begin
            w_exp.csr_write_enable = 1'b1; w_exp.ecall = 1'b1; w_exp.pc = pc;
        end else if (mr) begin
            w_exp.csr_write_enable = 1'b1; w_exp.mret = 1'b1;
        end else begin
            ill_exp = !known || (wr && addr[11:10] == 2'b11);
            rd_exp  = known ? old : 64'd0;
            if (!ill_exp && wr) begin
                w_exp.csr_write_enable = 1'b1; w_exp.plain = 1'b1;
                w_exp.csr_dest_addr = addr; w_exp.csr_write_data = nv;
            end
        end

        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_funct3 = f3; bus.in_csr_addr = addr; bus.in_rs1 = rs1;
        bus.in_src = src; bus.in_pc = pc; bus.in_ecall = ec; bus.in_mret = mr;
        drive_pm();
        @(posedge clk); #1;
        chk("exec_ready", bus.in_ready, 0);
        chk("exec_writer", writer, 0);

        // upstream keeps in_valid high with unrelated contents; must be ignored while busy
        @(negedge clk);
        bus.in_funct3 = 3'($urandom); bus.in_csr_addr = 12'($urandom); bus.in_rs1 = 5'($urandom);
        bus.in_src = {$urandom, $urandom}; bus.in_pc = {$urandom, $urandom};
        bus.in_ecall = 1'($urandom); bus.in_mret = 1'($urandom);
        drive_pm();
        @(posedge clk); #1;
        chk("commit_writer", writer, w_exp);
        chk("commit_pmode", pmode, pm_exp);
        chk("commit_valid", bus.out_valid, 0);

        @(negedge clk);
        if (ec) csrs_s.mepc = pc;
        drive_pm();
        rpc_exp = ec ? {csrs_s.mtvec[63:2], 2'b00} : mr ? csrs_s.mepc : 64'd0;
        @(posedge clk); #1;
        chk("resp_valid", bus.out_valid, 1);
        chk("resp_rd", bus.out_rd_data, rd_exp);
        chk("resp_illegal", bus.out_illegal, ill_exp);
        chk("resp_redir_v", bus.redirect_valid, ec || mr);
        chk("resp_redir_pc", bus.redirect_pc, rpc_exp);
        chk("resp_writer", writer, 0);

        @(negedge clk);
        bus.in_valid = 1'b0;
        drive_pm();
        if (update_pmode) pm_exp = new_pmode;
        @(posedge clk); #1;
        chk("idle_ready", bus.in_ready, 1);
        chk("idle_pmode", pmode, pm_exp);
        chk("idle_valid", bus.out_valid, 0);
    endtask

    logic [11:0] addr_tab [14] = '{12'h300, 12'h305, 12'h344, 12'h304, 12'h340, 12'h342,
                                   12'h343, 12'h341, 12'hB00, 12'hF14, 12'h180, 12'hF14,
                                   12'h7C0, 12'h000};
    logic [2:0]  f3_tab [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] a;
        bus.in_valid = 1'b0; bus.in_funct3 = '0; bus.in_csr_addr = '0; bus.in_rs1 = '0;
        bus.in_src = '0; bus.in_pc = '0; bus.in_ecall = 1'b0; bus.in_mret = 1'b0;
        csrs_s = '0; update_pmode = 1'b0; new_pmode = 2'd0;

        #12;
        chk("rst_pmode", pmode, 3);
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_writer", writer, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_redir", bus.redirect_valid, 0);
        @(negedge clk); rst = 1'b0;

        run_txn(3'b001, 12'h340, 5'd5, 64'hDEAD_BEEF, 64'h100, 0, 0);
        csrs_s.mscratch = 64'hDEAD_BEEF;
        run_txn(3'b010, 12'h340, 5'd0, 64'h1234, 64'h104, 0, 0);
        csrs_s.mstatus = 64'h8;
        run_txn(3'b111, 12'h300, 5'd8, 64'h0, 64'h108, 0, 0);
        csrs_s.mtvec = 64'h1000;
        run_txn(3'b110, 12'h305, 5'd4, 64'h0, 64'h10C, 0, 0);
        run_txn(3'b001, 12'hF14, 5'd1, 64'h55, 64'h110, 0, 0);
        run_txn(3'b010, 12'hF14, 5'd0, 64'h55, 64'h114, 0, 0);
        run_txn(3'b010, 12'h7C0, 5'd0, 64'h55, 64'h118, 0, 0);
        csrs_s.mtvec = 64'h8000_0001;
        run_txn(3'b000, 12'h000, 5'd0, 64'h0, 64'h8000_0100, 1, 0);
        csrs_s.mstatus = 64'h0; csrs_s.mepc = 64'h2000;
        upd_fix = 1'b1; np_fix = 2'd0;
        run_txn(3'b000, 12'h000, 5'd0, 64'h0, 64'h200, 0, 1);
        upd_fix = 1'b0;
        run_txn(3'b000, 12'h000, 5'd0, 64'h0, 64'h300, 1, 1);

        pm_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            csrs_s = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            a = addr_tab[$urandom_range(0, 13)];
            if (a == 12'h000) a = 12'($urandom);
            run_txn(f3_tab[$urandom_range(0, 5)], a,
                    ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                    {$urandom, $urandom}, {$urandom, $urandom},
                    $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        end

        // move pmode away from the reset value so the mid-flight reset is observable
        pm_rand = 1'b0; upd_fix = 1'b1; np_fix = 2'd1;
        run_txn(3'b010, 12'h300, 5'd0, 64'h0, 64'h400, 0, 0);
        upd_fix = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_funct3 = 3'b001; bus.in_csr_addr = 12'h340; bus.in_rs1 = 5'd3;
        bus.in_src = 64'hCAFE; bus.in_ecall = 1'b0; bus.in_mret = 1'b0;
        @(posedge clk);
        @(negedge clk); bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_writer_en", writer.csr_write_enable, 1);
        rst = 1'b1; #1;
        chk("midrst_writer", writer, 0);
        chk("midrst_valid", bus.out_valid, 0);
        chk("midrst_pmode", pmode, 3);
        chk("midrst_redir", bus.redirect_valid, 0);
        @(negedge clk); rst = 1'b0;
        pm_exp = 2'd3;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("postrst_writer", writer, 0);
            chk("postrst_valid", bus.out_valid, 0);
            chk("postrst_ready", bus.in_ready, 1);
        end
        chk("postrst_pmode", pmode, 3);
        run_txn(3'b001, 12'h340, 5'd7, 64'h77, 64'h500, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
